// File: rtl/cmd_dispatch_sched.sv
// Command queue and dispatcher: frame parser -> SPI / I2C engines / DUT enable.
// Optional WAIT-state watchdog is enabled with `define CMD_TIMEOUT_EN.
module cmd_dispatch_sched #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_valid,
    input  logic [7:0] cmd_type,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    output logic       ovf_err,
    output logic       spi_start,
    input  logic       spi_busy,
    input  logic       spi_done,
    output logic       i2c_start,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    output logic [7:0] eng_arg,
    output logic       dut_en,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_cmd,
    output logic [1:0] rsp_status
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ILL = 2'b01;
    localparam logic [1:0] ST_TO  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [15:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_cur_cmd;
    logic [7:0]  r_cur_arg;
    logic        r_ovf;
    logic        r_spi_start;
    logic        r_i2c_start;
    logic [7:0]  r_eng_arg;
    logic        r_dut_en;
    logic [7:0]  r_rsp_cmd;
    logic [1:0]  r_rsp_status;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_is_spi;
    logic        w_is_i2c;
    logic        w_is_on;
    logic        w_is_off;
    logic        w_tgt_done;
    logic        w_spi_go;
    logic        w_i2c_go;
    logic        w_dut_set;
    logic        w_dut_clr;
    logic        w_rsp_ld;
    logic [1:0]  w_rsp_st;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign w_push  = frame_valid && (!w_full || w_pop);

    assign w_is_spi   = (r_cur_cmd == 8'h01);
    assign w_is_i2c   = (r_cur_cmd == 8'h02);
    assign w_is_on    = (r_cur_cmd == 8'h03);
    assign w_is_off   = (r_cur_cmd == 8'h04);
    assign w_tgt_done = w_is_spi ? spi_done : i2c_done;

`ifdef CMD_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (r_state != S_WAIT)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 16'd1;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        w_nxt     = r_state;
        w_pop     = 1'b0;
        w_spi_go  = 1'b0;
        w_i2c_go  = 1'b0;
        w_dut_set = 1'b0;
        w_dut_clr = 1'b0;
        w_rsp_ld  = 1'b0;
        w_rsp_st  = ST_OK;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    w_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unique case (1'b1)
                    w_is_spi: begin
                        if (!spi_busy) begin
                            w_spi_go = 1'b1;
                            w_nxt    = S_WAIT;
                        end
                    end
                    w_is_i2c: begin
                        if (!i2c_busy) begin
                            w_i2c_go = 1'b1;
                            w_nxt    = S_WAIT;
                        end
                    end
                    w_is_on: begin
                        w_dut_set = 1'b1;
                        w_rsp_ld  = 1'b1;
                        w_nxt     = S_RESP;
                    end
                    w_is_off: begin
                        w_dut_clr = 1'b1;
                        w_rsp_ld  = 1'b1;
                        w_nxt     = S_RESP;
                    end
                    default: begin
                        w_rsp_ld = 1'b1;
                        w_rsp_st = ST_ILL;
                        w_nxt    = S_RESP;
                    end
                endcase
            end
            S_WAIT: begin
                if (w_tgt_done) begin
                    w_rsp_ld = 1'b1;
                    w_nxt    = S_RESP;
                end
`ifdef CMD_TIMEOUT_EN
                else if (r_to_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    w_rsp_ld = 1'b1;
                    w_rsp_st = ST_TO;
                    w_nxt    = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready)
                    w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cur_cmd <= '0;
            r_cur_arg <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {cmd_type, cmd_arg};
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                {r_cur_cmd, r_cur_arg} <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (frame_valid && !w_push)
                r_ovf <= 1'b1;
        end
    end

    // Starts are registered so each engine sees a clean single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_start  <= 1'b0;
            r_i2c_start  <= 1'b0;
            r_eng_arg    <= '0;
            r_dut_en     <= 1'b0;
            r_rsp_cmd    <= '0;
            r_rsp_status <= '0;
        end else begin
            r_spi_start <= w_spi_go;
            r_i2c_start <= w_i2c_go;
            if (w_spi_go || w_i2c_go)
                r_eng_arg <= r_cur_arg;
            if (w_dut_set)
                r_dut_en <= 1'b1;
            else if (w_dut_clr)
                r_dut_en <= 1'b0;
            if (w_rsp_ld) begin
                r_rsp_cmd    <= r_cur_cmd;
                r_rsp_status <= w_rsp_st;
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign ovf_err    = r_ovf;
    assign spi_start  = r_spi_start;
    assign i2c_start  = r_i2c_start;
    assign eng_arg    = r_eng_arg;
    assign dut_en     = r_dut_en;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_cmd    = r_rsp_cmd;
    assign rsp_status = r_rsp_status;

endmodule

// File: tb/tb_cmd_dispatch_sched.sv
// Directed bench for cmd_dispatch_sched.
// Timeout scenario is exercised when CMD_TIMEOUT_EN is defined.
module tb_cmd_dispatch_sched;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_valid;
    logic [7:0] cmd_type;
    logic [7:0] cmd_arg;
    logic       cmd_ready;
    logic       ovf_err;
    logic       spi_start;
    logic       spi_busy;
    logic       spi_done;
    logic       i2c_start;
    logic       i2c_busy;
    logic       i2c_done;
    logic [7:0] eng_arg;
    logic       dut_en;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_cmd;
    logic [1:0] rsp_status;

    always #5 clk = ~clk;

    cmd_dispatch_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(frame_valid), .cmd_type(cmd_type), .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready), .ovf_err(ovf_err),
        .spi_start(spi_start), .spi_busy(spi_busy), .spi_done(spi_done),
        .i2c_start(i2c_start), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
        .eng_arg(eng_arg), .dut_en(dut_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cmd(rsp_cmd), .rsp_status(rsp_status)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [9:0] rsp_q[$];
    logic [7:0] arg_q[$];

    always @(negedge clk)
        if (rst_n && rsp_valid && rsp_ready)
            rsp_q.push_back({rsp_cmd, rsp_status});

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] a);
        frame_valid = 1'b1;
        cmd_type    = t;
        cmd_arg     = a;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic wait_start(input logic use_i2c, input int lim,
                              output logic seen);
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (use_i2c ? i2c_start : spi_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [9:0] q_at(input int i);
        return (rsp_q.size() > i) ? rsp_q[i] : 10'h3ff;
    endfunction

    function automatic logic [23:0] outs();
        return {cmd_ready, ovf_err, spi_start, i2c_start, eng_arg,
                dut_en, rsp_valid, rsp_cmd, rsp_status};
    endfunction

    logic seen;
    logic bad;

    initial begin
        rst_n = 1'b0; frame_valid = 1'b0; cmd_type = '0; cmd_arg = '0;
        spi_busy = 1'b0; spi_done = 1'b0; i2c_busy = 1'b0;
        i2c_done = 1'b0; rsp_ready = 1'b0;
        #1;
        tick(); tick();
        chk("reset_outs", 32'(outs()), 32'h800000);
        rst_n = 1'b1;
        tick();

        // 1: SPI command, start latency and response
        send(8'h01, 8'hA5);
        chk("t1_nostart_a", 32'(spi_start), 0);
        tick();
        chk("t1_nostart_b", 32'(spi_start), 0);
        tick();
        chk("t1_start", 32'(spi_start), 1);
        chk("t1_arg", 32'(eng_arg), 32'hA5);
        tick();
        chk("t1_pulse_end", 32'(spi_start), 0);
        chk("t1_no_rsp", 32'(rsp_valid), 0);
        repeat (4) tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp", 32'({rsp_cmd, rsp_status}), 32'({8'h01, 2'b00}));
        chk("t1_arg_held", 32'(eng_arg), 32'hA5);
        tick();
        chk("t1_rsp_stable", 32'({rsp_valid, rsp_cmd, rsp_status}),
            32'({1'b1, 8'h01, 2'b00}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t1_rsp_done", 32'(rsp_valid), 0);

        // 2: I2C gated by busy; foreign done ignored
        i2c_busy = 1'b1;
        send(8'h02, 8'h3C);
        seen = 1'b0;
        repeat (10) begin
            if (i2c_start) seen = 1'b1;
            tick();
        end
        chk("t2_held_busy", 32'(seen), 0);
        i2c_busy = 1'b0;
        wait_start(1'b1, 5, seen);
        chk("t2_start", 32'(seen), 1);
        chk("t2_arg", 32'(eng_arg), 32'h3C);
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t2_ignore_spi_done", 32'(rsp_valid), 0);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        chk("t2_rsp", 32'({rsp_valid, rsp_cmd, rsp_status}),
            32'({1'b1, 8'h02, 2'b00}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: DUT on, illegal, DUT off back-to-back
        rsp_q.delete();
        rsp_ready = 1'b1;
        send(8'h03, 8'h00);
        send(8'h7F, 8'h00);
        send(8'h04, 8'h00);
        seen = 1'b0;
        repeat (20) begin
            if (dut_en) seen = 1'b1;
            tick();
        end
        chk("t3_dut_rose", 32'(seen), 1);
        chk("t3_dut_fell", 32'(dut_en), 0);
        chk("t3_nrsp", 32'(rsp_q.size()), 3);
        chk("t3_rsp0", 32'(q_at(0)), 32'({8'h03, 2'b00}));
        chk("t3_rsp1", 32'(q_at(1)), 32'({8'h7F, 2'b01}));
        chk("t3_rsp2", 32'(q_at(2)), 32'({8'h04, 2'b00}));

        // 4: overflow with engine busy
        rsp_q.delete();
        arg_q.delete();
        spi_busy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++)
            send(8'h01, 8'(i));
        chk("t4_full", 32'(cmd_ready), 0);
        chk("t4_ovf", 32'(ovf_err), 1);
        spi_busy = 1'b0;
        repeat (200) begin
            spi_done = 1'b0;
            if (spi_start) begin
                arg_q.push_back(eng_arg);
                spi_done = 1'b1;
            end
            tick();
        end
        spi_done = 1'b0;
        chk("t4_nrsp", 32'(rsp_q.size()), DEPTH + 1);
        chk("t4_nstart", 32'(arg_q.size()), DEPTH + 1);
        for (int i = 0; i < DEPTH + 1; i++)
            chk($sformatf("t4_order%0d", i),
                32'((arg_q.size() > i) ? arg_q[i] : 8'hFF), i);
        chk("t4_rsp0", 32'(q_at(0)), 32'({8'h01, 2'b00}));
        chk("t4_ready_again", 32'(cmd_ready), 1);
        chk("t4_ovf_sticky", 32'(ovf_err), 1);
        rsp_ready = 1'b0;

        // 5: response back-pressure
        send(8'h01, 8'h11);
        send(8'h01, 8'h22);
        wait_start(1'b0, 10, seen);
        chk("t5_start1", 32'(seen), 1);
        chk("t5_arg1", 32'(eng_arg), 32'h11);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t5_rsp_valid", 32'(rsp_valid), 1);
        bad = 1'b0;
        repeat (20) begin
            if (!rsp_valid || rsp_cmd != 8'h01 || rsp_status != 2'b00 ||
                spi_start)
                bad = 1'b1;
            tick();
        end
        chk("t5_stall_stable", 32'(bad), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wait_start(1'b0, 10, seen);
        chk("t5_start2", 32'(seen), 1);
        chk("t5_arg2", 32'(eng_arg), 32'h22);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t5_rsp2", 32'({rsp_valid, rsp_cmd}), 32'({1'b1, 8'h01}));
        rsp_ready = 1'b1;
        tick();

        // 6: watchdog, then reset while waiting
        send(8'h03, 8'h00);
        repeat (5) tick();
        chk("t6_dut_on", 32'(dut_en), 1);
        rsp_ready = 1'b0;
`ifdef CMD_TIMEOUT_EN
        send(8'h01, 8'h5A);
        wait_start(1'b0, 10, seen);
        chk("t6_start", 32'(seen), 1);
        repeat (TO - 1) tick();
        chk("t6_not_yet", 32'(rsp_valid), 0);
        tick();
        chk("t6_timeout", 32'({rsp_valid, rsp_cmd, rsp_status}),
            32'({1'b1, 8'h01, 2'b10}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
        send(8'h01, 8'h5A);
        wait_start(1'b0, 10, seen);
        chk("t6_wait_start", 32'(seen), 1);
`ifndef CMD_TIMEOUT_EN
        repeat (40) tick();
        chk("t6_no_limit", 32'(rsp_valid), 0);
`endif
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outs", 32'(outs()), 32'h800000);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            if (spi_start || rsp_valid) seen = 1'b1;
            tick();
        end
        chk("t6_queue_dropped", 32'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
